// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch controller and its FIFO.
//   - state_e          : fetch FSM states (BOOT / RUN / DRAIN / HALTED)
//   - RESET_PC_DEFAULT : default byte address of the first fetch after reset
//   - INST_W, PC_W     : instruction and program counter widths
//   - PC_INC           : byte increment between sequential fetches
//   - align_pc()       : forces a byte address onto a word boundary
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int          INST_W           = 32;
  localparam int          PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Drop the byte-offset bits so the result is a legal word address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO holding {pc, instruction} pairs
// returned by the instruction memory, waiting for the decode stage.
//
// Ports
//   i_clk        in   core clock, rising edge
//   i_rst_n      in   asynchronous active-low reset; clears pointers, count and storage
//   i_push       in   write {i_push_pc, i_push_inst} at the tail
//   i_push_pc    in   byte address of the pushed instruction
//   i_push_inst  in   pushed instruction word
//   i_pop        in   drop the head entry
//   i_flush      in   discard all entries (wins over push/pop in the same cycle)
//   o_head_pc    out  pc of the head entry
//   o_head_inst  out  instruction of the head entry
//   o_count      out  number of valid entries
//   o_empty      out  no valid entries
//   o_full       out  DEPTH valid entries
//
// The head outputs are a pointer-selected read of the storage registers, so
// they never depend combinationally on any input of this block.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [PC_W-1:0]   i_push_pc,
  input  logic [INST_W-1:0] i_push_inst,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [PC_W-1:0]   o_head_pc,
  output logic [INST_W-1:0] o_head_inst,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_full    = (r_count == CNT_DEPTH);
  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= {PC_W{1'b0}};
        r_inst_mem[i] <= {INST_W{1'b0}};
      end
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_pc_mem[r_wr_ptr]   <= i_push_pc;
        r_inst_mem[r_wr_ptr] <= i_push_inst;
        r_wr_ptr             <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. Owns the program counter, issues
// word reads to a fixed-latency-1 synchronous instruction memory, buffers the
// returned words in fetch_fifo and hands them to decode over valid/ready.
// Handles redirects (branch/jump) with a flush and halt requests with a drain.
//
// Ports
//   i_clk             in   core clock, rising edge
//   i_rst_n           in   asynchronous active-low reset
//   o_imem_req        out  read request this cycle
//   o_imem_addr       out  word-aligned byte address of the request (the pc)
//   i_imem_rdata      in   read data, valid the cycle after a request
//   i_redirect_valid  in   one-cycle pulse: load i_redirect_pc and flush
//   i_redirect_pc     in   redirect target byte address
//   i_halt_req        in   level: stop issuing fetches while high
//   o_inst_valid      out  FIFO head holds an instruction
//   i_inst_ready      in   decode accepts the head this cycle
//   o_inst_data       out  instruction at the FIFO head
//   o_inst_pc         out  byte address of o_inst_data
//   o_halted          out  FSM is in HALTED
//   o_misalign_err    out  sticky: a redirect target had non-zero low bits
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [PC_W-1:0]   o_imem_addr,
  input  logic [INST_W-1:0] i_imem_rdata,
  input  logic              i_redirect_valid,
  input  logic [PC_W-1:0]   i_redirect_pc,
  input  logic              i_halt_req,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst_data,
  output logic [PC_W-1:0]   o_inst_pc,
  output logic              o_halted,
  output logic              o_misalign_err
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] OCC_LIMIT = CW'(DEPTH);

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_epoch;
  logic            r_inflight;
  logic            r_inflight_epoch;
  logic [PC_W-1:0] r_inflight_pc;
  logic            r_misalign;

  logic          w_redirect;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_occ;
  logic          w_empty;
  logic          w_full;

  // A redirect during BOOT is ignored; everywhere else it flushes and reloads the pc.
  assign w_redirect = i_redirect_valid && (r_state != ST_BOOT);

  // Slots already promised: buffered entries plus the outstanding read. A pop in
  // this cycle is deliberately not credited, so the FIFO can never overflow.
  assign w_occ  = w_count + {{(CW-1){1'b0}}, r_inflight};
  assign w_room = !w_full && (w_occ < OCC_LIMIT);

  // No request in the redirect cycle: the pc still holds the old stream.
  assign w_issue = (r_state == ST_RUN) && !i_halt_req && !w_redirect && w_room;

  // The epoch compare drops any response whose request predates the latest
  // redirect; a response landing in the redirect cycle itself is dropped too,
  // because the flush in that cycle wins over the push.
  assign w_push = r_inflight && (r_inflight_epoch == r_epoch) && !w_redirect;

  // A handshake in the redirect cycle still completes: decode owns that word.
  assign w_pop = o_inst_valid && i_inst_ready;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_pc   (r_inflight_pc),
    .i_push_inst (i_imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_head_pc   (o_inst_pc),
    .o_head_inst (o_inst_data),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // FSM, program counter, redirect epoch, outstanding-read tracking and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= ST_BOOT;
      r_pc             <= RESET_PC;
      r_epoch          <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_inflight_pc    <= {PC_W{1'b0}};
      r_misalign       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_epoch <= r_epoch;
        r_inflight_pc    <= r_pc;
      end else begin
        r_inflight_epoch <= r_inflight_epoch;
        r_inflight_pc    <= r_inflight_pc;
      end

      if (w_redirect) begin
        r_epoch <= ~r_epoch;
        r_pc    <= align_pc(i_redirect_pc);
        if (i_redirect_pc[1:0] != 2'b00) begin
          r_misalign <= 1'b1;
        end else begin
          r_misalign <= r_misalign;
        end
        r_state <= i_halt_req ? ST_HALTED : ST_RUN;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + PC_INC;
        end else begin
          r_pc <= r_pc;
        end
        case (r_state)
          ST_BOOT: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (i_halt_req) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_RUN;
            end
          end
          // Wait for the last outstanding read to land before declaring halted.
          ST_DRAIN: begin
            if (!r_inflight) begin
              r_state <= ST_HALTED;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
          ST_HALTED: begin
            if (!i_halt_req) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_HALTED;
            end
          end
          default: begin
            r_state <= ST_BOOT;
          end
        endcase
      end
    end
  end

  assign o_imem_req     = w_issue;
  assign o_imem_addr    = r_pc;
  assign o_inst_valid   = !w_empty;
  assign o_halted       = (r_state == ST_HALTED);
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Each scenario starts from a
// fresh reset so cycle positions are known; cycle k is the interval after the
// k-th rising edge following rst_n release. Expected handshakes are queued by
// the stimulus; an independent monitor pops and compares on every accepted
// transfer. Memory model: word i holds the value i, latency one cycle.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc_now = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt_req       (halt_req),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst_data      (inst_data),
    .o_inst_pc        (inst_pc),
    .o_halted         (halted),
    .o_misalign_err   (misalign_err)
  );

  // Instruction memory: word i = i; garbage when no request was made.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle, a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got pc %h data %h expected none", inst_pc, inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", inst_pc, mon_e[63:32]);
        chk("sb_data", inst_data, mon_e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic goto(input int k);
    while (cyc_now < k) step();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_seq(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc0 + 32'(4 * i), (pc0 >> 2) + 32'(i)});
    end
  endtask

  // Hold reset, verify reset values, release just after a rising edge (cycle 0).
  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    inst_ready = rdy;
    cyc_now    = 0;
  endtask

  // Wait (bounded) until every queued transfer has been seen, then stop accepting.
  task automatic drain_expected(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    inst_ready = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Sequential streaming from reset
    do_reset(1'b1);
    expect_seq(32'h0, 8);
    goto(1); settle();
    chk("A_req_c1", {31'b0, imem_req}, 32'd1);
    chk("A_addr_c1", imem_addr, 32'h0);
    goto(2); settle();
    chk("A_valid_c2", {31'b0, inst_valid}, 32'd0);
    chk("A_addr_c2", imem_addr, 32'h4);
    goto(3); settle();
    chk("A_valid_c3", {31'b0, inst_valid}, 32'd1);
    chk("A_pc_c3", inst_pc, 32'h0);
    drain_expected("A_all_seen");

    // Backpressure: four slots fill, then requests stop
    do_reset(1'b0);
    expect_seq(32'h0, 8);
    goto(4); settle();
    chk("B_req_c4", {31'b0, imem_req}, 32'd1);
    chk("B_addr_c4", imem_addr, 32'hC);
    goto(5); settle();
    chk("B_req_c5", {31'b0, imem_req}, 32'd0);
    goto(10); settle();
    chk("B_req_c10", {31'b0, imem_req}, 32'd0);
    chk("B_valid_c10", {31'b0, inst_valid}, 32'd1);
    chk("B_pc_c10", inst_pc, 32'h0);
    chk("B_addr_c10", imem_addr, 32'h10);
    goto(11);
    inst_ready = 1'b1;
    drain_expected("B_all_seen");

    // Redirect with 3 buffered and one in flight
    do_reset(1'b0);
    expect_seq(32'h100, 4);
    goto(5); settle();
    chk("C_valid_pre", {31'b0, inst_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    settle();
    chk("C_valid_r1", {31'b0, inst_valid}, 32'd0);
    chk("C_req_r1", {31'b0, imem_req}, 32'd1);
    chk("C_addr_r1", imem_addr, 32'h100);
    goto(7); settle();
    chk("C_valid_r2", {31'b0, inst_valid}, 32'd0);
    goto(8); settle();
    chk("C_valid_r3", {31'b0, inst_valid}, 32'd1);
    chk("C_pc_r3", inst_pc, 32'h100);
    drain_expected("C_all_seen");

    // Redirect coinciding with the handshake of pc 0x8
    do_reset(1'b1);
    expect_seq(32'h0, 3);
    expect_seq(32'h200, 2);
    goto(5); settle();
    chk("D_pc_hs", inst_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    settle();
    chk("D_valid_r1", {31'b0, inst_valid}, 32'd0);
    chk("D_addr_r1", imem_addr, 32'h200);
    goto(8); settle();
    chk("D_pc_r3", inst_pc, 32'h200);
    drain_expected("D_all_seen");

    // Halt: drain, halted, FIFO still drains, resume sequentially
    do_reset(1'b0);
    expect_seq(32'h0, 5);
    goto(4);
    halt_req = 1'b1;
    settle();
    chk("E_req_c4", {31'b0, imem_req}, 32'd0);
    goto(5); settle();
    chk("E_halted_c5", {31'b0, halted}, 32'd0);
    goto(6); settle();
    chk("E_halted_c6", {31'b0, halted}, 32'd1);
    chk("E_req_c6", {31'b0, imem_req}, 32'd0);
    goto(7);
    inst_ready = 1'b1;
    goto(9); settle();
    chk("E_halted_c9", {31'b0, halted}, 32'd1);
    chk("E_pc_c9", inst_pc, 32'h8);
    goto(10); settle();
    chk("E_valid_c10", {31'b0, inst_valid}, 32'd0);
    goto(11);
    halt_req = 1'b0;
    settle();
    chk("E_req_c11", {31'b0, imem_req}, 32'd0);
    goto(12); settle();
    chk("E_halted_c12", {31'b0, halted}, 32'd0);
    chk("E_req_c12", {31'b0, imem_req}, 32'd1);
    chk("E_addr_c12", imem_addr, 32'hC);
    drain_expected("E_all_seen");

    // Misaligned redirect, sticky error, asynchronous reset mid-run
    do_reset(1'b1);
    expect_seq(32'h0, 2);
    expect_seq(32'h100, 3);
    goto(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    settle();
    chk("F_addr_r1", imem_addr, 32'h100);
    chk("F_misalign_r1", {31'b0, misalign_err}, 32'd1);
    drain_expected("F_all_seen");
    repeat (3) step();
    settle();
    chk("F_misalign_sticky", {31'b0, misalign_err}, 32'd1);
    chk("F_valid_before_rst", {31'b0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("F_rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("F_rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("F_rst_req", {31'b0, imem_req}, 32'd0);
    chk("F_rst_pc", inst_pc, 32'h0);
    chk("F_rst_data", inst_data, 32'h0);
    chk("F_rst_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller that sequences the instruction memory. It owns the program counter, issues word reads to the synchronous instruction memory, and buffers returned instructions in a small FIFO. It presents them to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and also handles branch/jump redirects and halt requests from the core.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; bits [1:0] must be 0.
- DEPTH, 4, instruction FIFO entries; power of two, ≥2.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory this cycle.
- imem_addr  out  32  byte address of the request; word aligned; memory indexes word addr>>2.
- imem_rdata  in  32  read data; valid exactly one cycle after the cycle imem_req=1 (fixed latency 1, no backpressure).
- redirect_valid  in  1  one-cycle pulse; load new PC and flush.
- redirect_pc  in  32  redirect target byte address.
- halt_req  in  1  level; stop issuing new fetches while high.
- inst_valid  out  1  FIFO head holds an instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  instruction at FIFO head.
- inst_pc  out  32  byte address of inst_data.
- halted  out  1  high in HALTED state.
- misalign_err  out  1  sticky; set when redirect_pc[1:0]≠0; cleared only by reset.

## Operation
- FSM states: BOOT, RUN, DRAIN, HALTED.
- BOOT: entered on reset; no request. Goes to RUN on the next edge.
- RUN: issue imem_req=1 with imem_addr=pc when occupancy+inflight < DEPTH and halt_req=0. On issue, pc ← pc+4 (wraps modulo 2^32). If halt_req=1, go to DRAIN.
- DRAIN: no new requests; the in-flight response, if any, is still written. Go to HALTED when inflight=0.
- HALTED: no requests; FIFO contents are still drained by decode. Goes to RUN when halt_req falls, or on redirect.
- Returned data and the PC of its request are pushed into the FIFO in the response cycle. Occupancy counting does not credit a pop in the same cycle, so the FIFO never overflows.
- Redirect, accepted in any state except BOOT:
  - FIFO is cleared.
  - In-flight response is discarded using an epoch bit toggled on redirect and tagged on each request.
  - pc ← {redirect_pc[31:2],2'b00}; misalign_err set if redirect_pc[1:0]≠0.
  - Next state is RUN, unless halt_req=1, in which case it is HALTED.
  - No request is issued in the redirect cycle.
- Redirect and handshake in the same cycle: the handshake completes (the consumer owns that instruction), then the flush applies.
- Redirect in BOOT is ignored.
- Reset mid-operation: all state is cleared immediately and in-flight data is dropped.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, halted=0, misalign_err=0; pc=RESET_PC, epoch=0, FSM=BOOT.
- First request: second rising edge after rst_n deasserts.
- Fetch latency: request in cycle N → data in FIFO at the end of N+1 → inst_valid=1 in cycle N+2.
- Throughput: 1 instruction/cycle sustained when inst_ready=1.
- Redirect in cycle R: first new request in R+1; first new inst_valid in R+3; inst_valid=0 from R+1 until then.
- Outputs inst_valid, inst_data and inst_pc are driven from registers only.

## Structure
- Shared package fetch_pkg holds:
  - FSM state enum (BOOT/RUN/DRAIN/HALTED).
  - Default RESET_PC.
  - Instruction width (32) and the PC increment constant (4).
- One sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO of {pc,inst} with push, pop, flush, count, empty and full. It uses the same clk/rst_n.
- Inflight tracking (1 bit plus epoch) and the FSM live in fetch_ctrl.

## Test plan
- Reset release with RESET_PC=0, inst_ready=1, memory word i = i:
  - requests at addresses 0,4,8,… one per cycle.
  - inst_pc/inst_data = 0/0, 4/1, 8/2 from the 3rd cycle after release, with no bubbles.
- Backpressure: hold inst_ready=0 for 10 cycles.
  - Requests stop once occupancy+inflight=4.
  - Exactly 4 instructions are buffered, and none are lost or duplicated after release.
- Redirect to 0x100 while the FIFO holds 3 entries and one request is in flight:
  - FIFO empties and the stale response is dropped.
  - Next inst_pc=0x100 appears 3 cycles after the pulse.
- Redirect in the same cycle as a valid/ready handshake of pc 0x8: 0x8 counts as consumed exactly once, and the next output is the redirect target.
- halt_req held high:
  - DRAIN then HALTED; halted=1; imem_req=0.
  - FIFO still drains.
  - Releasing halt_req resumes at the next sequential PC.
- Misaligned redirect 0x103: fetch resumes at 0x100, misalign_err=1 and stays set until rst_n asserts mid-run, which clears all outputs asynchronously.
